// File: rtl/gate_response_checker.sv
// Response checker for a 2-input gate DUT: compares registered y against func_sel, counts
// mismatches and input coverage. Optional `GATE_CHK_STOP_ON_ERR_EN ends a run at the first mismatch.
module gate_response_checker #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned ERR_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       func_sel,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       cov,
    output logic [2:0]       first_err,
    output logic             first_err_vld
);

    localparam int unsigned STAB_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
    state_t state, state_nxt;

    logic              a_q, b_q, y_q;
    logic [2:0]        func_q;
    logic [1:0]        prev_pair;
    logic [STAB_W-1:0] stab_cnt;
    logic              checked;
    logic [TMO_W-1:0]  tmo_cnt;

    logic [1:0] pair;
    logic       arm;
    logic       stable;
    logic       expected;
    logic       stop_err;

    assign pair   = {a_q, b_q};
    assign arm    = start && (state != CHECK);
    assign stable = (pair == prev_pair);

`ifdef GATE_CHK_STOP_ON_ERR_EN
    assign stop_err = first_err_vld;
`else
    assign stop_err = 1'b0;
`endif

    always_comb begin
        expected = 1'b0;
        unique case (func_q)
            3'd0: expected = a_q & b_q;
            3'd1: expected = a_q | b_q;
            3'd2: expected = ~(a_q & b_q);
            3'd3: expected = ~(a_q | b_q);
            3'd4: expected = a_q ^ b_q;
            3'd5: expected = ~(a_q ^ b_q);
            3'd6: expected = a_q;
            3'd7: expected = ~a_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A check landing on the timeout cycle is still recorded before DONE is entered.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = CHECK;
            CHECK:   if (cov == 4'hF || tmo_cnt == TMO_LAST || stop_err) state_nxt = DONE;
            DONE:    if (start) state_nxt = CHECK;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q           <= 1'b0;
            b_q           <= 1'b0;
            y_q           <= 1'b0;
            func_q        <= '0;
            prev_pair     <= '0;
            stab_cnt      <= '0;
            checked       <= 1'b0;
            tmo_cnt       <= '0;
            err_count     <= '0;
            cov           <= '0;
            first_err     <= '0;
            first_err_vld <= 1'b0;
        end else begin
            a_q <= a;
            b_q <= b;
            y_q <= y;
            if (arm) begin
                func_q        <= func_sel;
                err_count     <= '0;
                cov           <= '0;
                first_err     <= '0;
                first_err_vld <= 1'b0;
                tmo_cnt       <= '0;
                prev_pair     <= pair;
                stab_cnt      <= '0;
                checked       <= 1'b0;
            end else if (state == CHECK) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
                if (!stable) begin
                    prev_pair <= pair;
                    stab_cnt  <= '0;
                    checked   <= 1'b0;
                end else begin
                    if (stab_cnt < STAB_LAST) stab_cnt <= stab_cnt + STAB_W'(1);
                    // One check per stable interval; later y activity in the interval is ignored.
                    if (stab_cnt == STAB_LAST && !checked) begin
                        checked   <= 1'b1;
                        cov[pair] <= 1'b1;
                        if (y_q != expected) begin
                            if (err_count != '1) err_count <= err_count + ERR_W'(1);
                            if (!first_err_vld) begin
                                first_err     <= {pair, y_q};
                                first_err_vld <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign busy = (state == CHECK);
    assign done = (state == DONE);
    assign pass = done && (err_count == '0) && (cov == 4'hF);

endmodule

// File: tb/tb_gate_response_checker.sv
// Scoreboard bench for gate_response_checker: emulates a gate DUT, predicts each run's result
// when the run is started, and compares when done rises.
module tb_gate_response_checker;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned TMO    = 64;
`ifdef GATE_CHK_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic [2:0] func_sel = 3'd0;
    logic       a        = 1'b0;
    logic       b        = 1'b0;
    logic       y        = 1'b0;
    logic       busy, done, pass, first_err_vld;
    logic [7:0] err_count;
    logic [3:0] cov;
    logic [2:0] first_err;

    gate_response_checker #(
        .SETTLE_CYCLES (SETTLE),
        .ERR_W         (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .func_sel     (func_sel),
        .a            (a),
        .b            (b),
        .y            (y),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .err_count    (err_count),
        .cov          (cov),
        .first_err    (first_err),
        .first_err_vld(first_err_vld)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic [1:0] v;
        logic [7:0] h;
    } step_t;

    typedef struct packed {
        logic [3:0] cov;
        logic [7:0] err;
        logic       pass;
        logic [2:0] fe;
        logic       fev;
        int         lat;
    } exp_t;

    step_t       steps[$];
    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int unsigned start_cyc = 0;
    bit          done_seen = 1'b0;
    logic        done_d = 1'b0;
    logic [2:0]  dut_gate = 3'd0;
    bit          glitch = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic logic f_eval(input logic [2:0] fn, input logic [1:0] v);
        logic va, vb;
        va = v[1];
        vb = v[0];
        case (fn)
            3'd0:    return va & vb;
            3'd1:    return va | vb;
            3'd2:    return ~(va & vb);
            3'd3:    return ~(va | vb);
            3'd4:    return va ^ vb;
            3'd5:    return ~(va ^ vb);
            3'd6:    return va;
            default: return ~va;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [1:0] v, input int unsigned h);
        steps.push_back({v, 8'(h)});
    endtask

    always @(negedge clk) begin
        if (rst_n && done && !done_d) begin
            exp_t e;
            done_seen = 1'b1;
            chk("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cov",           32'(cov),           32'(e.cov));
                chk("err_count",     32'(err_count),     32'(e.err));
                chk("pass",          32'(pass),          32'(e.pass));
                chk("first_err",     32'(first_err),     32'(e.fe));
                chk("first_err_vld", 32'(first_err_vld), 32'(e.fev));
                if (e.lat >= 0) chk("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
        end
        done_d = done;
    end

    task automatic begin_run(input logic [2:0] fsel, input logic [2:0] gate, input bit gl, input int lat);
        exp_t e;
        e     = '0;
        e.lat = lat;
        foreach (steps[i]) begin
            logic yv;
            if (e.cov == 4'hF || (STOP && e.fev)) break;
            if (steps[i].h >= 8'(SETTLE + 1)) begin
                yv = f_eval(gate, steps[i].v);
                e.cov[steps[i].v] = 1'b1;
                if (yv != f_eval(fsel, steps[i].v)) begin
                    e.err = e.err + 8'd1;
                    if (!e.fev) begin
                        e.fev = 1'b1;
                        e.fe  = {steps[i].v, yv};
                    end
                end
            end
        end
        e.pass = (e.err == 8'd0) && (e.cov == 4'hF);
        exp_q.push_back(e);
        dut_gate  = gate;
        glitch    = gl;
        done_seen = 1'b0;
        func_sel  = fsel;
        start     = 1'b1;
        tick();
        start_cyc = cyc;
        start     = 1'b0;
        func_sel  = ~fsel;
    endtask

    task automatic drive_steps();
        foreach (steps[i]) begin
            for (int k = 0; k < int'(steps[i].h); k++) begin
                {a, b} = steps[i].v;
                y = f_eval(dut_gate, steps[i].v) ^ (glitch && k < 2);
                tick();
            end
        end
    endtask

    task automatic finish_run(input string name);
        for (int i = 0; i < 200 && !done_seen; i++) tick();
        chk({name, "_done"}, 32'(done_seen), 32'd1);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        steps.delete();
        tick();
    endtask

    task automatic run(input string name, input logic [2:0] fsel, input logic [2:0] gate,
                       input bit gl, input int lat);
        begin_run(fsel, gate, gl, lat);
        chk({name, "_busy_run"}, 32'(busy), 32'd1);
        drive_steps();
        finish_run(name);
    endtask

    task automatic add4();
        add(2'b00, 8); add(2'b01, 8); add(2'b10, 8); add(2'b11, 8);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_done"},  32'(done),          32'd0);
        chk({tag, "_pass"},  32'(pass),          32'd0);
        chk({tag, "_err"},   32'(err_count),     32'd0);
        chk({tag, "_cov"},   32'(cov),           32'd0);
        chk({tag, "_fe"},    32'(first_err),     32'd0);
        chk({tag, "_fev"},   32'(first_err_vld), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        add4();                                   run("and_ok",   3'd0, 3'd0, 1'b0, -1);
        add4();                                   run("or_as_and", 3'd0, 3'd1, 1'b0, -1);
        add(2'b00, 8); add(2'b11, 8);             run("timeout",  3'd0, 3'd0, 1'b0, int'(TMO));
        add(2'b00, 8); add(2'b01, 3); add(2'b10, 5); add(2'b11, 8);
                                                  run("glitch",   3'd0, 3'd0, 1'b1, int'(TMO));
        add(2'b00, 8); add(2'b01, 8); add(2'b00, 8); add(2'b01, 8); add(2'b10, 8); add(2'b11, 8);
                                                  run("repeat",   3'd0, 3'd1, 1'b0, -1);
        add4();                                   run("xor_ok",   3'd4, 3'd4, 1'b0, -1);
        add4();                                   run("nota_ok",  3'd7, 3'd7, 1'b0, -1);
        add4();                                   run("nand_as_and", 3'd0, 3'd2, 1'b0, -1);
        add4();                                   run("xor_as_xnor", 3'd5, 3'd4, 1'b0, -1);

        // Reset in the middle of a run after two checks (one mismatching).
        add(2'b00, 8); add(2'b01, 8);
        begin_run(3'd0, 3'd1, 1'b0, -1);
        drive_steps();
        chk("mid_busy", 32'(busy),      32'(!STOP));
        chk("mid_err",  32'(err_count), 32'd1);
        chk("mid_cov",  32'(cov),       32'h3);
        rst_n = 1'b0;
        #2;
        chk_zero("mid_rst");
        exp_q.delete();
        steps.delete();
        tick();
        rst_n = 1'b1;
        tick();
        add4();                                   run("after_rst", 3'd0, 3'd0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
